// File: rtl/div_pkg.sv
// Shared encodings for the sequential RV32 divider: funct3[1:0] operation codes,
// FSM state codes and small operation-decode helpers.
package div_pkg;

  typedef enum logic [1:0] {
    OP_DIV  = 2'b00,
    OP_DIVU = 2'b01,
    OP_REM  = 2'b10,
    OP_REMU = 2'b11
  } op_e;

  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_CALC = 2'b01,
    S_FIX  = 2'b10
  } state_e;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_rem_op(input logic [1:0] op);
    return (op == OP_REM) || (op == OP_REMU);
  endfunction

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift the next dividend bit into the partial
// remainder and subtract the divisor magnitude when it fits.
module div_step #(
  parameter int N = 32
) (
  input  logic [N:0]   i_rem,
  input  logic         i_quo_msb,
  input  logic [N-1:0] i_divisor,
  output logic [N:0]   o_rem,
  output logic         o_q_bit
);

  logic [N+1:0] w_shift;
  logic [N+1:0] w_diff;

  assign w_shift = {i_rem, i_quo_msb};
  assign w_diff  = w_shift - {2'b00, i_divisor};
  // No borrow out of the widened subtraction means the divisor fits.
  assign o_q_bit = ~w_diff[N+1];
  assign o_rem   = o_q_bit ? w_diff[N:0] : w_shift[N:0];

endmodule

// File: rtl/seq_divider.sv
// Multi-cycle restoring divider for RV32M DIV/DIVU/REM/REMU, one quotient bit per clock.
// Optional DIV_FAST_SPECIAL_EN: divide-by-zero and signed overflow bypass the iterations.
module seq_divider
  import div_pkg::*;
#(
  parameter int N = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [1:0]   op,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  input  logic         flush,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] result
);

  localparam int CW = $clog2(N) + 1;

  state_e         r_state;
  logic [CW-1:0]  r_cnt;
  logic [N:0]     r_rem;
  logic [N-1:0]   r_quo;
  logic [N-1:0]   r_b;
  logic [N-1:0]   r_a;
  logic [N-1:0]   r_result;
  logic           r_sign_q;
  logic           r_sign_r;
  logic           r_rem_op;
  logic           r_div0;
  logic           r_ovf;
  logic           r_busy;
  logic           r_done;

  logic           w_signed;
  logic           w_div0;
  logic           w_ovf;
  logic           w_skip;
  logic [N-1:0]   w_a_abs;
  logic [N-1:0]   w_b_abs;
  logic [N:0]     w_rem_next;
  logic           w_q_bit;
  logic [N-1:0]   w_rem_lo;
  logic [N-1:0]   w_quo_fix;
  logic [N-1:0]   w_rem_fix;
  logic [N-1:0]   w_fix_result;

  assign w_signed = is_signed_op(op);
  assign w_div0   = (divisor == {N{1'b0}});
  assign w_ovf    = w_signed && (dividend == {1'b1, {(N-1){1'b0}}}) && (divisor == {N{1'b1}});
  assign w_a_abs  = (w_signed && dividend[N-1]) ? -dividend : dividend;
  assign w_b_abs  = (w_signed && divisor[N-1])  ? -divisor  : divisor;

`ifdef DIV_FAST_SPECIAL_EN
  assign w_skip = w_div0 | w_ovf;
`else
  assign w_skip = 1'b0;
`endif

  div_step #(.N(N)) u_step (
    .i_rem     (r_rem),
    .i_quo_msb (r_quo[N-1]),
    .i_divisor (r_b),
    .o_rem     (w_rem_next),
    .o_q_bit   (w_q_bit)
  );

  assign w_rem_lo  = r_rem[N-1:0];
  assign w_quo_fix = r_sign_q ? -r_quo : r_quo;
  assign w_rem_fix = r_sign_r ? -w_rem_lo : w_rem_lo;

  // Final result selection: RISC-V special cases override the iterated value.
  always_comb begin
    w_fix_result = {N{1'b0}};
    if (r_div0) begin
      w_fix_result = r_rem_op ? r_a : {N{1'b1}};
    end else if (r_ovf) begin
      w_fix_result = r_rem_op ? {N{1'b0}} : r_a;
    end else begin
      w_fix_result = r_rem_op ? w_rem_fix : w_quo_fix;
    end
  end

  // Divider control FSM with datapath registers and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_cnt    <= {CW{1'b0}};
      r_rem    <= {(N+1){1'b0}};
      r_quo    <= {N{1'b0}};
      r_b      <= {N{1'b0}};
      r_a      <= {N{1'b0}};
      r_result <= {N{1'b0}};
      r_sign_q <= 1'b0;
      r_sign_r <= 1'b0;
      r_rem_op <= 1'b0;
      r_div0   <= 1'b0;
      r_ovf    <= 1'b0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
    end else if (flush) begin
      r_state <= S_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_done <= 1'b0;
          if (start) begin
            r_a      <= dividend;
            r_quo    <= w_a_abs;
            r_b      <= w_b_abs;
            r_rem    <= {(N+1){1'b0}};
            r_cnt    <= {CW{1'b0}};
            r_sign_q <= w_signed & (dividend[N-1] ^ divisor[N-1]);
            r_sign_r <= w_signed & dividend[N-1];
            r_rem_op <= is_rem_op(op);
            r_div0   <= w_div0;
            r_ovf    <= w_ovf;
            r_busy   <= 1'b1;
            r_state  <= w_skip ? S_FIX : S_CALC;
          end else begin
            r_busy <= 1'b0;
          end
        end
        S_CALC: begin
          r_done <= 1'b0;
          r_rem  <= w_rem_next;
          r_quo  <= {r_quo[N-2:0], w_q_bit};
          r_cnt  <= r_cnt + {{(CW-1){1'b0}}, 1'b1};
          if (r_cnt == CW'(N - 1)) begin
            r_state <= S_FIX;
          end else begin
            r_state <= S_CALC;
          end
        end
        S_FIX: begin
          r_result <= w_fix_result;
          r_done   <= 1'b1;
          r_busy   <= 1'b0;
          r_state  <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
        end
      endcase
    end
  end

  assign busy   = r_busy;
  assign done   = r_done;
  assign result = r_result;

endmodule

// File: tb/tb_seq_divider.sv
// Directed bench for seq_divider: scoreboard queue of expected results, latency and
// control checks for flush, start-while-busy, reset mid-operation and special cases.
module tb_seq_divider;

  localparam int N   = 32;
  localparam int LAT = N + 1;
`ifdef DIV_FAST_SPECIAL_EN
  localparam int LAT_SP = 1;
`else
  localparam int LAT_SP = N + 1;
`endif

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    op = 2'b00;
  logic [N-1:0]  dividend = '0;
  logic [N-1:0]  divisor = '0;
  logic          flush = 1'b0;
  logic          busy;
  logic          done;
  logic [N-1:0]  result;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] sb_q[$];
  logic [31:0] last_result = 32'h0;

  seq_divider #(.N(N)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .op(op), .dividend(dividend),
    .divisor(divisor), .flush(flush), .busy(busy), .done(done), .result(result)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    logic s;
    logic r;
    s = ~o[0];
    r = o[1];
    if (b == 32'h0) return r ? a : 32'hFFFF_FFFF;
    if (s && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return r ? 32'h0 : a;
    if (s) return r ? 32'($signed(a) % $signed(b)) : 32'($signed(a) / $signed(b));
    return r ? a % b : a / b;
  endfunction

  // Issue one op (start driven #1 after an edge), optionally pulse start again at
  // glitch_at cycles into the operation, then wait for done and score the result.
  task automatic do_op(input string tag, input logic [1:0] o, input logic [31:0] a,
                       input logic [31:0] b, input logic [31:0] exp, input int exp_lat,
                       input int glitch_at);
    int cycles;
    logic got;
    logic [31:0] e;
    sb_q.push_back(exp);
    op = o; dividend = a; divisor = b; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    dividend = 32'hDEAD_BEEF; divisor = 32'h0000_0003; op = 2'b01;
    check({tag, "_busy"}, {31'h0, busy}, 32'h1);
    cycles = 0;
    got = 1'b0;
    while (!got && cycles < 100) begin
      if (glitch_at != 0 && cycles == glitch_at) start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      cycles++;
      if (done) got = 1'b1;
    end
    check({tag, "_done"}, {31'h0, got}, 32'h1);
    e = sb_q.pop_front();
    if (got) begin
      check({tag, "_result"}, result, e);
      check({tag, "_lat"}, cycles, exp_lat);
      check({tag, "_nobusy"}, {31'h0, busy}, 32'h0);
      last_result = e;
    end
  endtask

  initial begin
    logic [31:0] ra, rb;
    logic [1:0]  ro;
    logic        sp;
    int          dcount;

    #12;
    check("rst_busy",   {31'h0, busy}, 32'h0);
    check("rst_done",   {31'h0, done}, 32'h0);
    check("rst_result", result, 32'h0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    do_op("divu_100_7", 2'b01, 32'd100, 32'd7, 32'd14, LAT, 0);
    do_op("remu_100_7", 2'b11, 32'd100, 32'd7, 32'd2, LAT, 0);
    do_op("div_m7_2",   2'b00, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, LAT, 0);
    do_op("rem_m7_2",   2'b10, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, LAT, 0);
    do_op("rem_7_m2",   2'b10, 32'd7, 32'hFFFF_FFFE, 32'd1, LAT, 0);
    do_op("div_5_0",    2'b00, 32'd5, 32'd0, 32'hFFFF_FFFF, LAT_SP, 0);
    do_op("rem_5_0",    2'b10, 32'd5, 32'd0, 32'd5, LAT_SP, 0);
    do_op("div_ovf",    2'b00, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, LAT_SP, 0);
    do_op("rem_ovf",    2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0, LAT_SP, 0);
    do_op("divu_big",   2'b01, 32'hFFFF_FFFF, 32'd16, 32'h0FFF_FFFF, LAT, 0);

    // Flush in the 10th CALC cycle: no done, result untouched, then a clean op.
    op = 2'b01; dividend = 32'd1000; divisor = 32'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (9) @(posedge clk);
    #1 flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0;
    check("flush_busy", {31'h0, busy}, 32'h0);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("flush_nodone", dcount, 0);
    check("flush_result", result, last_result);
    do_op("div_after_flush", 2'b00, 32'd1000, 32'hFFFF_FFFD, 32'hFFFF_FEB3, LAT, 0);

    // Start pulsed mid-operation must not disturb the in-flight divide.
    do_op("start_busy", 2'b01, 32'd200, 32'd9, 32'd22, LAT, 5);
    dcount = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done) dcount++;
    end
    check("start_busy_nosecond", dcount, 0);

    for (int i = 0; i < 6; i++) begin
      ra = $urandom;
      rb = $urandom >> (i * 5);
      ro = 2'(i);
      sp = (rb == 32'h0) || (!ro[0] && ra == 32'h8000_0000 && rb == 32'hFFFF_FFFF);
      do_op("rand", ro, ra, rb, model(ro, ra, rb), sp ? LAT_SP : LAT, 0);
    end

    // Asynchronous reset in the middle of CALC.
    op = 2'b01; dividend = 32'd77; divisor = 32'd5; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (5) @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("mid_rst_busy",   {31'h0, busy}, 32'h0);
    check("mid_rst_done",   {31'h0, done}, 32'h0);
    check("mid_rst_result", result, 32'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    do_op("after_rst", 2'b11, 32'd77, 32'd5, 32'd2, LAT, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
